// File: rtl/line_subsampler.sv
// line_subsampler: keeps one video line out of every R lines of an AXI-stream frame.
// Optional statistics outputs are built only when LINE_SUBSAMPLER_STATS_EN is defined.
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   ss_en_i, ss_ratio_i         subsampling enable and ratio, latched at each start of frame
//   video_i_*                   upstream stream (tdata/tvalid/tready/tlast/tuser)
//   video_o_*                   downstream stream, registered with one cycle of latency
//   frames_cnt_o                (stats) accepted start-of-frame beats, wrapping
//   dropped_lines_o             (stats) lines dropped in the previous frame
`timescale 1ns/1ps
module line_subsampler #(
   parameter int TDATA_WIDTH = 32,
   parameter int RATIO_WIDTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   ss_en_i,
   input  logic [RATIO_WIDTH-1:0] ss_ratio_i,
   input  logic [TDATA_WIDTH-1:0] video_i_tdata,
   input  logic                   video_i_tvalid,
   output logic                   video_i_tready,
   input  logic                   video_i_tlast,
   input  logic                   video_i_tuser,
   output logic [TDATA_WIDTH-1:0] video_o_tdata,
   output logic                   video_o_tvalid,
   input  logic                   video_o_tready,
   output logic                   video_o_tlast,
   output logic                   video_o_tuser
`ifdef LINE_SUBSAMPLER_STATS_EN
   ,
   output logic [15:0]            frames_cnt_o,
   output logic [15:0]            dropped_lines_o
`endif
);
   typedef enum logic [1:0] {WAIT_SOF, KEEP, DROP} state_t;
   state_t state, state_d;
   logic [RATIO_WIDTH-1:0] ratio_q, ratio_d, line_idx, line_d;
   logic [RATIO_WIDTH-1:0] eff_ratio, use_ratio, base_idx, nxt_idx;
   logic out_free, keep, acc, adv;
   assign out_free = !video_o_tvalid || video_o_tready;
   // a start-of-frame beat is always kept, so it must wait for room in the output register even in DROP
   assign keep = video_i_tuser || state == KEEP;
   assign video_i_tready = !rst_n_i || !keep || out_free;
   assign acc = video_i_tvalid && video_i_tready;
   // only beats inside a frame move the line counter; WAIT_SOF discards everything but tuser
   assign adv = acc && (video_i_tuser || state != WAIT_SOF);
   assign eff_ratio = (ss_en_i && ss_ratio_i != '0) ? ss_ratio_i : RATIO_WIDTH'(1);
   always_comb begin
      use_ratio = video_i_tuser ? eff_ratio : ratio_q;
      base_idx = video_i_tuser ? '0 : line_idx;
      nxt_idx = (base_idx == use_ratio - RATIO_WIDTH'(1)) ? '0 : base_idx + RATIO_WIDTH'(1);
      ratio_d = (acc && video_i_tuser) ? eff_ratio : ratio_q;
      line_d = !adv ? line_idx : (video_i_tlast ? nxt_idx : base_idx);
      state_d = !adv ? state : (video_i_tlast ? ((nxt_idx == '0) ? KEEP : DROP) : (video_i_tuser ? KEEP : state));
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= WAIT_SOF;
         ratio_q <= RATIO_WIDTH'(1);
         line_idx <= '0;
      end else begin
         state <= state_d;
         ratio_q <= ratio_d;
         line_idx <= line_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         video_o_tvalid <= 1'b0;
         video_o_tdata <= '0;
         video_o_tlast <= 1'b0;
         video_o_tuser <= 1'b0;
      end else if (acc && keep) begin
         video_o_tvalid <= 1'b1;
         video_o_tdata <= video_i_tdata;
         video_o_tlast <= video_i_tlast;
         video_o_tuser <= video_i_tuser;
      end else if (video_o_tready) begin
         video_o_tvalid <= 1'b0;
      end
   end
`ifdef LINE_SUBSAMPLER_STATS_EN
   logic [15:0] drop_cnt;
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         frames_cnt_o <= '0;
         dropped_lines_o <= '0;
         drop_cnt <= '0;
      end else if (acc && video_i_tuser) begin
         frames_cnt_o <= frames_cnt_o + 16'd1;
         dropped_lines_o <= drop_cnt;
         drop_cnt <= '0;
      end else if (acc && video_i_tlast && state == DROP) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_line_subsampler.sv
// tb_line_subsampler: randomized bench for line_subsampler against a per-frame line-keeping model.
`timescale 1ns/1ps
module tb_line_subsampler;
   localparam int DW = 32;
   localparam int RW = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ss_en = 1'b0;
   logic [RW-1:0] ss_ratio = RW'(1);
   logic [DW-1:0] i_data = '0;
   logic i_valid = 1'b0, i_last = 1'b0, i_user = 1'b0;
   logic i_ready;
   logic [DW-1:0] o_data;
   logic o_valid, o_last, o_user;
   logic o_ready;
`ifdef LINE_SUBSAMPLER_STATS_EN
   logic [15:0] frames_cnt, dropped_lines;
`endif
   line_subsampler #(.TDATA_WIDTH(DW), .RATIO_WIDTH(RW)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .ss_en_i(ss_en), .ss_ratio_i(ss_ratio),
      .video_i_tdata(i_data), .video_i_tvalid(i_valid), .video_i_tready(i_ready),
      .video_i_tlast(i_last), .video_i_tuser(i_user),
      .video_o_tdata(o_data), .video_o_tvalid(o_valid), .video_o_tready(o_ready),
      .video_o_tlast(o_last), .video_o_tuser(o_user)
`ifdef LINE_SUBSAMPLER_STATS_EN
      , .frames_cnt_o(frames_cnt), .dropped_lines_o(dropped_lines)
`endif
   );
   always #5 clk = ~clk;
   int checks = 0, failures = 0;
   logic [DW+1:0] exp_q[$];
   bit rand_ready = 1'b0, fixed_ready = 1'b1;
   int exp_frames = 0, exp_dropped = 0, cur_dropped = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   always @(posedge clk) begin
      #1;
      o_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
   end
   // every cycle the output is valid it must show the oldest expected beat; it leaves the queue only when taken
   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         if (exp_q.size() == 0) check("extra_beat", 64'(exp_q.size()), 64'd1);
         else begin
            check("beat", 64'({o_user, o_last, o_data}), 64'(exp_q[0]));
            if (o_ready) void'(exp_q.pop_front());
         end
      end
   end
   task automatic send(input logic [DW-1:0] d, input logic last, input logic user, input bit kept);
      int n = 0;
      bit acc = 1'b0;
      i_data = d; i_last = last; i_user = user; i_valid = 1'b1;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = i_ready;
         @(posedge clk);
         #1;
         n++;
      end
      i_valid = 1'b0;
      if (!acc) check("accept_timeout", 64'(n), 64'd0);
      else if (kept) check("latency", 64'({o_valid, o_user, o_last, o_data}), 64'({1'b1, user, last, d}));
      if (rand_ready && $urandom_range(0, 3) == 0) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send_frame(input int lines, input int px, input bit chg);
      int r = ss_en ? ((ss_ratio == 0) ? 1 : int'(ss_ratio)) : 1;
      int kept_lines = 0;
      exp_dropped = cur_dropped;
      exp_frames++;
      for (int l = 0; l < lines; l++) begin
         bit kept = (l % r) == 0;
         kept_lines += kept ? 1 : 0;
         for (int p = 0; p < px; p++) begin
            logic [DW-1:0] d = $urandom;
            logic last = (p == px - 1);
            logic user = (l == 0 && p == 0);
            if (kept) exp_q.push_back({user, last, d});
            send(d, last, user, kept);
            if (user) begin
`ifdef LINE_SUBSAMPLER_STATS_EN
               check("frames_cnt", 64'(frames_cnt), 64'(exp_frames & 16'hFFFF));
               check("dropped_lines", 64'(dropped_lines), 64'(exp_dropped));
`endif
               if (chg) begin
                  ss_ratio = RW'($urandom);
                  ss_en = 1'($urandom);
               end
            end
         end
      end
      cur_dropped = lines - kept_lines;
   endtask
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      exp_frames = 0; exp_dropped = 0; cur_dropped = 0;
      check("rst_out", 64'({o_valid, o_last, o_user, o_data}), 64'd0);
      check("rst_tready", 64'(i_ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_tready", 64'(i_ready), 64'd1);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end
   initial begin
      do_reset();
      for (int i = 0; i < 3; i++) send(DW'($urandom), 1'(i == 1), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("wait_sof_discard", 64'(o_valid), 64'd0);
      ss_en = 1'b1; ss_ratio = RW'(2);
      send_frame(4, 8, 1'b0);
      drain();
      ss_en = 1'b0; ss_ratio = RW'(3);
      send_frame(3, 8, 1'b0);
      drain();
      ss_en = 1'b1; ss_ratio = RW'(0);
      send_frame(3, 4, 1'b0);
      ss_ratio = RW'(2);
      send_frame(3, 1, 1'b0);
      ss_ratio = RW'(3);
      send_frame(5, 3, 1'b0);
      drain();
      rand_ready = 1'b1;
      ss_ratio = RW'(3);
      send_frame(7, 6, 1'b1);
      for (int f = 0; f < 8; f++) send_frame($urandom_range(1, 9), $urandom_range(1, 6), 1'b1);
      drain();
      rand_ready = 1'b0;
      fixed_ready = 1'b1;
      ss_en = 1'b1; ss_ratio = RW'(1);
      exp_q.push_back({1'b1, 1'b0, 32'h1000});
      send(32'h1000, 1'b0, 1'b1, 1'b1);
      for (int p = 1; p < 4; p++) begin
         exp_q.push_back({1'b0, 1'(p == 3), DW'(32'h1000 + p)});
         send(DW'(32'h1000 + p), 1'(p == 3), 1'b0, 1'b1);
      end
      exp_q.push_back({1'b0, 1'b0, 32'h2000});
      send(32'h2000, 1'b0, 1'b0, 1'b1);
      fixed_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 1'b0, 32'h2001});
      send(32'h2001, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("stall_hold", 64'({o_valid, o_data}), 64'({1'b1, 32'h2001}));
      do_reset();
      fixed_ready = 1'b1;
      for (int p = 2; p < 4; p++) send(DW'(32'h2000 + p), 1'(p == 3), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("rst_resume_idle", 64'(o_valid), 64'd0);
      ss_ratio = RW'(2);
      send_frame(4, 3, 1'b0);
      drain();
      do_reset();
      ss_en = 1'b1; ss_ratio = RW'(4);
      send_frame(8, 2, 1'b0);
      send_frame(8, 2, 1'b0);
      send_frame(1, 2, 1'b0);
      drain();
`ifdef LINE_SUBSAMPLER_STATS_EN
      check("stats_frames_final", 64'(frames_cnt), 64'd3);
      check("stats_dropped_final", 64'(dropped_lines), 64'd6);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/line_subsampler.md
LINE_SUBSAMPLER -- requirements
Module: line_subsampler

Interface
REQ-001 Parameter TDATA_WIDTH, default 32: video tdata width in bits.
REQ-002 Parameter RATIO_WIDTH, default 4: width of the line-ratio input.
REQ-003 clk_i  input  1  single clock; all logic is on the rising edge.
REQ-004 rst_n_i  input  1  reset, synchronous, active-low.
REQ-005 ss_en_i  input  1  1 = subsample lines; 0 = pass all lines.
REQ-006 ss_ratio_i  input  RATIO_WIDTH  keep 1 line of every ss_ratio_i lines; 0 means 1.
REQ-007 video_i_tdata  input  TDATA_WIDTH  pixel data from the upstream px_subsampler.
REQ-008 video_i_tvalid  input  1  input beat valid.
REQ-009 video_i_tready  output  1  input beat accepted.
REQ-010 video_i_tlast  input  1  end of line.
REQ-011 video_i_tuser  input  1  start of frame.
REQ-012 video_o_tdata  output  TDATA_WIDTH  registered output data.
REQ-013 video_o_tvalid  output  1  output beat valid.
REQ-014 video_o_tready  input  1  downstream ready.
REQ-015 video_o_tlast  output  1  end of line, forwarded from the kept beat.
REQ-016 video_o_tuser  output  1  start of frame, forwarded from the kept beat.

Function
REQ-017 An input beat SHALL be accepted when video_i_tvalid and video_i_tready are both 1; an output beat SHALL be transferred when video_o_tvalid and video_o_tready are both 1.
REQ-018 The FSM SHALL have three states: WAIT_SOF, KEEP and DROP.
REQ-019 In WAIT_SOF, video_i_tready SHALL be 1, and every beat without tuser SHALL be discarded.
REQ-020 An accepted tuser=1 beat in any state SHALL do all of the following:
- latch the effective ratio R (max(ss_ratio_i,1) if ss_en_i=1, else 1) and ss_en_i;
- clear line_idx to 0;
- be handled as a KEEP beat.
REQ-021 In KEEP, video_i_tready SHALL equal !video_o_tvalid || video_o_tready, and each accepted beat SHALL load the output register one cycle later.
REQ-022 In DROP, video_i_tready SHALL be 1, and accepted beats SHALL NOT appear on the output.
REQ-023 On an accepted tlast=1 beat, line_idx SHALL advance:
- line_idx becomes 0 if line_idx == R-1, otherwise line_idx+1;
- the next state is KEEP if the new line_idx is 0, otherwise DROP.
REQ-024 A beat with both tuser=1 and tlast=1 SHALL be forwarded, then REQ-023 SHALL apply with line_idx starting from 0.
REQ-025 Changes on ss_ratio_i and ss_en_i SHALL take effect only at the next accepted tuser=1 beat.
REQ-026 If the output register is full and not consumed, video_o_tdata, video_o_tlast and video_o_tuser SHALL hold stable.
REQ-027 Simultaneous output transfer and new KEEP input acceptance SHALL sustain one beat per cycle with no bubble.
REQ-028 Latency from input acceptance to video_o_tvalid SHALL be exactly 1 cycle.

Reset
REQ-029 While rst_n_i is 0 at a clock edge, all of the following SHALL hold:
- video_o_tvalid, video_o_tdata, video_o_tlast and video_o_tuser are 0;
- line_idx is 0, R is 1, and the state is WAIT_SOF.
REQ-030 Reset mid-frame SHALL drop the pending output beat, and the block SHALL resume output only at the next tuser=1 beat.
REQ-031 video_i_tready SHALL be 1 during reset and in the cycle after reset is released.

Configuration
REQ-032 With macro LINE_SUBSAMPLER_STATS_EN defined, the block SHALL add two outputs:
- frames_cnt_o  output  16  count of accepted tuser=1 beats; wraps at 0xFFFF; reset 0.
- dropped_lines_o  output  16  dropped lines in the previous frame, captured at each tuser=1 beat; reset 0.
REQ-033 With LINE_SUBSAMPLER_STATS_EN undefined, these ports and their logic SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-034 ss_en_i=1, ss_ratio_i=2, 4-line x 8-px frame, video_o_tready=1 -> lines 0 and 2 output (16 beats); first beat has tuser=1; tlast on beats 8 and 16.
REQ-035 ss_en_i=0, ss_ratio_i=3, 3-line frame -> all 24 beats output unchanged with 1-cycle latency.
REQ-036 ss_ratio_i=0 -> all lines forwarded, identical to ratio 1.
REQ-037 ss_ratio_i=3 with random video_o_tready (50%) -> no beat lost or duplicated in kept lines; tdata stable while stalled.
REQ-038 Reset asserted in the middle of line 1, then a new frame -> video_o_tvalid=0 until the new tuser beat; the new frame starts at line_idx 0.
REQ-039 LINE_SUBSAMPLER_STATS_EN defined, ratio 4, two 8-line frames -> after the third tuser beat, frames_cnt_o=3 and dropped_lines_o=6.
